// File: rtl/unpool_stream_pkg.sv
// Shared helpers for the max-unpooling stage: clogb2, pooling-index width, FSM states.
package unpool_stream_pkg;

  function automatic int clogb2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int POOL         = 2;
  localparam int PINDEX_W_DEF = clogb2(POOL * POOL);

  // TOP emits the upper window row from hold, BOT replays the row buffer.
  typedef enum logic {
    ST_TOP = 1'b0,
    ST_BOT = 1'b1
  } state_e;

endpackage

// File: rtl/unpool_stream_if.sv
// Pooled-in / unpooled-out stream bundle; slave side is the unpool stage.
interface unpool_stream_if #(
  parameter int D            = 64,
  parameter int PINDEX_WIDTH = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [D-1:0]              in_data;
  logic [D*PINDEX_WIDTH-1:0] in_pindex;
  logic                      out_valid;
  logic                      out_ready;
  logic [D-1:0]              out_data;
  logic                      out_eol;
  logic                      out_eof;

  modport master (
    output in_valid, in_data, in_pindex, out_ready,
    input  in_ready, out_valid, out_data, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_data, in_pindex, out_ready,
    output in_ready, out_valid, out_data, out_eol, out_eof
  );
endinterface

// File: rtl/unpool_stream_sel.sv
// Window-position selector: builds one unpooled pixel for position k.
// UNPOOL_REPLICATE_EN removes the index port and replicates data to every position.
module unpool_sel #(
  parameter int   D            = 64,
  parameter int   PINDEX_WIDTH = 2,
  parameter logic FILL         = 1'b0
) (
  input  logic [D-1:0]              i_data,
`ifndef UNPOOL_REPLICATE_EN
  input  logic [D*PINDEX_WIDTH-1:0] i_pindex,
  input  logic [1:0]                i_k,
`endif
  output logic [D-1:0]              o_pix
);

  for (genvar d = 0; d < D; d++) begin : g_ch
`ifdef UNPOOL_REPLICATE_EN
    assign o_pix[d] = i_data[d];
`else
    // Indices >= 4 (wider PINDEX_WIDTH) never match k, so all positions get FILL.
    assign o_pix[d] = (i_pindex[d*PINDEX_WIDTH +: PINDEX_WIDTH] == PINDEX_WIDTH'(i_k))
                      ? i_data[d] : FILL;
`endif
  end

endmodule

// File: rtl/unpool_stream.sv
// 2x2 max-unpooling stream stage: each pooled pixel becomes a 2x2 window in raster order.
// Optional build macro UNPOOL_REPLICATE_EN: nearest-neighbour upsampling, no index storage.
module unpool_stream
  import unpool_stream_pkg::*;
#(
  parameter int   D            = 64,
  parameter int   PW           = 16,
  parameter int   PH           = 16,
  parameter int   PINDEX_WIDTH = PINDEX_W_DEF,
  parameter logic FILL         = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  unpool_stream_if.slave  bus
);

  localparam int CW = clogb2(PW);
  localparam int RW = clogb2(PH);

  state_e                    r_state;
  logic                      r_hold_v;
  logic                      r_sub;
  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  logic [D-1:0]              r_hold_data;
  logic [D-1:0]              r_buf_data [PW];
`ifndef UNPOOL_REPLICATE_EN
  logic [D*PINDEX_WIDTH-1:0] r_hold_idx;
  logic [D*PINDEX_WIDTH-1:0] r_buf_idx  [PW];
  logic [D*PINDEX_WIDTH-1:0] w_sel_idx;
`endif

  logic       w_out_valid, w_fire_out, w_in_ready, w_fire_in, w_last_col, w_eol;
  logic [D-1:0] w_sel_data, w_pix;
  logic [1:0]   w_k;

  always_comb begin
    w_out_valid = !rst && ((r_state == ST_TOP && r_hold_v) || r_state == ST_BOT);
    w_fire_out  = w_out_valid && bus.out_ready;
    w_in_ready  = !rst && r_state == ST_TOP && (!r_hold_v || (w_fire_out && r_sub));
    w_fire_in   = bus.in_valid && w_in_ready;
    w_last_col  = (r_col == CW'(PW - 1));
    w_eol       = w_out_valid && r_sub && w_last_col;
    w_k         = {r_state == ST_BOT, r_sub};
    w_sel_data  = (r_state == ST_BOT) ? r_buf_data[r_col] : r_hold_data;
`ifndef UNPOOL_REPLICATE_EN
    w_sel_idx   = (r_state == ST_BOT) ? r_buf_idx[r_col] : r_hold_idx;
`endif
  end

  unpool_sel #(
    .D(D), .PINDEX_WIDTH(PINDEX_WIDTH), .FILL(FILL)
  ) u_sel (
    .i_data   (w_sel_data),
`ifndef UNPOOL_REPLICATE_EN
    .i_pindex (w_sel_idx),
    .i_k      (w_k),
`endif
    .o_pix    (w_pix)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_pix;
  assign bus.out_eol   = w_eol;
  assign bus.out_eof   = w_eol && r_state == ST_BOT && r_row == RW'(PH - 1);

  // The buffer is filled from hold on its k=1 beat, so a pixel accepted on the
  // last TOP beat (next row, col 0) can wait in hold without clobbering BOT data.
  always_ff @(posedge clk) begin
    if (w_fire_in) begin
      r_hold_data <= bus.in_data;
`ifndef UNPOOL_REPLICATE_EN
      r_hold_idx  <= bus.in_pindex;
`endif
    end
    if (r_state == ST_TOP && w_fire_out && r_sub) begin
      r_buf_data[r_col] <= r_hold_data;
`ifndef UNPOOL_REPLICATE_EN
      r_buf_idx[r_col]  <= r_hold_idx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_TOP;
      r_hold_v <= 1'b0;
      r_sub    <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      case (r_state)
        ST_TOP: begin
          if (w_fire_out) begin
            r_sub <= ~r_sub;
            if (r_sub) begin
              r_hold_v <= w_fire_in;
              if (w_last_col) begin
                r_col   <= '0;
                r_state <= ST_BOT;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end else if (w_fire_in) begin
            r_hold_v <= 1'b1;
          end
        end
        ST_BOT: begin
          if (w_fire_out) begin
            r_sub <= ~r_sub;
            if (r_sub) begin
              if (w_last_col) begin
                r_col   <= '0;
                r_state <= ST_TOP;
                r_row   <= (r_row == RW'(PH - 1)) ? '0 : r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_TOP;
      endcase
    end
  end

endmodule

// File: doc/unpool_stream.md
# unpool_stream

Max-unpooling stage for the decoder half of the binary encoder-decoder network. It consumes the pooled stream produced by the encoder processing elements: one D-channel binary activation word plus one pooling index per channel for each pooled pixel. It re-expands each pooled pixel to a POOL 2×2 window and emits unpooled pixels in raster order. Each bit is placed at the window position recorded by its index; all other positions get the fill value. It sits between the pooled-feature buffer and the first decoder convolution window generator.

## Interface
- D, 64, channels per pixel (1 bit each)
- PW, 16, pooled row width in pixels (output row width 2*PW)
- PH, 16, pooled rows per frame (output frame 2*PH rows)
- PINDEX_WIDTH, 2, bits per pooling index (clogb2(2*2))
- FILL, 1'b0, bit written to non-selected window positions

Ports:
- clk  in  1  clock; single clock domain, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pooled pixel valid
- in_ready  out  1  block can accept pooled pixel
- in_data  in  D  binary activations, bit d = channel d
- in_pindex  in  D*PINDEX_WIDTH  channel d index at [d*PINDEX_WIDTH +: PINDEX_WIDTH]; index k = 2*dy+dx
- out_valid  out  1  unpooled pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  D  unpooled pixel
- out_eol  out  1  qualifies last beat of an output row
- out_eof  out  1  qualifies last beat of a frame

## Operation
- Output bit for channel d at window position k = (in_pindex[d] == k) ? in_data[d] : FILL.
- Storage: holding register (data+indices, valid flag hold_v), row buffer of PW entries × D*(1+PINDEX_WIDTH) bits, counters col (0..PW-1), sub (0..1), row (0..PH-1).
- FSM TOP (after reset):
  - An accepted input loads hold and is written to row buffer[col].
  - The block emits two beats from hold: k=0, then k=1 (sub 0, 1).
  - in_ready = !rst && state==TOP && (!hold_v || (out_ready && out_valid && sub==1)).
  - After the k=1 beat of col==PW-1, go to BOT with col=0, sub=0.
- FSM BOT:
  - in_ready = 0.
  - The block emits 2*PW beats from row buffer[col]: k=2, then k=3, per column.
  - After the last beat, go to TOP; row increments and wraps to 0 after PH-1.
- out_eol = 1 on the sub==1, col==PW-1 beat in both TOP and BOT.
- out_eof = out_eol in BOT with row==PH-1.
- Index values ≥4 cannot occur for PINDEX_WIDTH=2. For wider PINDEX_WIDTH, an index ≥4 selects no position, so all four positions get FILL.

## Timing
- Reset values: out_valid=0, out_eol=0, out_eof=0, in_ready=0 while rst=1. hold_v=0, state=TOP, counters=0.
- in_ready=1 on the first cycle after rst falls.
- Latency: input accepted at cycle t → k=0 beat is valid at t+1 (hold registered; out_data combinational from hold/buffer).
- Throughput: in TOP, one input per 2 output beats with no bubbles. Back-to-back acceptance happens on the cycle of the sub==1 handshake.
- BOT: out_valid=1 every cycle until 2*PW beats are accepted. The TOP→BOT and BOT→TOP transitions insert no idle cycle.
- out_data, out_eol, out_eof hold stable while out_valid && !out_ready.
- Reset mid-frame or mid-row discards hold and the buffer state. The next input is treated as pixel (row 0, col 0).

## Configuration
- UNPOOL_REPLICATE_EN defined:
  - in_pindex is ignored and no index storage is built.
  - All four window positions output in_data (nearest-neighbour upsampling).
  - Row buffer width is D.
- Undefined: index-directed max-unpooling as specified above.

## Structure
- Shared package or include: clogb2, PINDEX_WIDTH derivation, and FSM state encoding (TOP, BOT).
- One natural sub-module: unpool_sel. It is combinational: (data, pindex, k) → D-bit pixel with FILL. One instance is fed from hold in TOP and from the buffer in BOT via a mux.

## Test plan
All scenarios use D=4, PW=2, PH=2, FILL=0, unless stated.
- Index routing: in_data=4'b1111, pindex of channel d = d, out_ready=1 → first input's TOP beats 4'b0001 (k0), 4'b0010 (k1). BOT beats for that column: 4'b0100 (k2), 4'b1000 (k3).
- Full frame: 4 pooled pixels streamed back-to-back → exactly 16 output beats. out_eol on beats 4, 8, 12, 16; out_eof only on beat 16. in_ready=0 during beats 5–8 and 13–16.
- Backpressure: out_ready toggled 1,0,0,1 each beat → no beat lost or duplicated, and outputs stay stable while stalled. in_ready stays 0 while hold is occupied.
- Reset mid-operation: rst pulsed after output beat 6 → all outputs 0 during reset, in_ready=1 the next cycle. The next 16 beats form a complete frame with eof on beat 16.
- Frame wrap: two consecutive frames → row counter returns to 0 and the second frame's eof falls on beat 32 overall.
- UNPOOL_REPLICATE_EN: in_data=4'b1010 with arbitrary pindex → all four positions of that pixel output 4'b1010.
